tmr_voted_pipeline: RTL and testbench



---
 rtl/tmr_voted_pipeline.sv | 116 +++++++++++
 tb/tb_tmr_voted_pipeline.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tmr_voted_pipeline.sv
// Triplicated WIDTH x DEPTH pipeline. Every copy reloads from its own majority voter each cycle, and copy mismatches are flagged and counted.
// Optional error-injection ports are enabled by defining TMR_ERR_INJECT_EN.
module tmr_voted_pipeline #(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 2,
   parameter int               CNT_W   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en_i,
   input  logic             vld_i,
   input  logic [WIDTH-1:0] din_a,
   input  logic [WIDTH-1:0] din_b,
   input  logic [WIDTH-1:0] din_c,
   output logic [WIDTH-1:0] dout_a,
   output logic [WIDTH-1:0] dout_b,
   output logic [WIDTH-1:0] dout_c,
   output logic [WIDTH-1:0] dout_v,
   output logic             vld_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt,
`ifdef TMR_ERR_INJECT_EN
   input  logic             inj_i,
   input  logic [3:0]       inj_stage_i,
   input  logic [1:0]       inj_copy_i,
   input  logic [WIDTH-1:0] inj_mask_i,
`endif
   input  logic             clr_cnt_i
);

   function automatic logic [WIDTH-1:0] maj(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic [WIDTH-1:0] z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   logic [WIDTH-1:0] dat_q [DEPTH][3];
   logic [WIDTH-1:0] dat_d [DEPTH][3];
   logic [WIDTH-1:0] src_dat [DEPTH][3];
   logic [2:0]       vld_q [DEPTH];
   logic [2:0]       vld_d [DEPTH];
   logic [2:0]       src_vld [DEPTH];
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mis;

   always_comb begin
      src_dat = '{default: '0};
      src_vld = '{default: '0};
      dat_d   = '{default: '0};
      vld_d   = '{default: '0};
      mis     = 1'b0;
      // Stage 0 is fed from the input copies; the single valid tag is fanned out to all three.
      src_dat[0][0] = din_a;
      src_dat[0][1] = din_b;
      src_dat[0][2] = din_c;
      src_vld[0]    = {3{vld_i}};
      for (int s = 1; s < DEPTH; s++) begin
         for (int c = 0; c < 3; c++) src_dat[s][c] = dat_q[s-1][c];
         src_vld[s] = vld_q[s-1];
      end
      for (int s = 0; s < DEPTH; s++) begin
         for (int c = 0; c < 3; c++) begin
            // Each copy gets its own voter; a stall re-votes the stage onto itself.
            if (en_i) begin
               dat_d[s][c] = maj(src_dat[s][0], src_dat[s][1], src_dat[s][2]);
               vld_d[s][c] = (src_vld[s][0] & src_vld[s][1]) | (src_vld[s][0] & src_vld[s][2]) |
                             (src_vld[s][1] & src_vld[s][2]);
            end else begin
               dat_d[s][c] = maj(dat_q[s][0], dat_q[s][1], dat_q[s][2]);
               vld_d[s][c] = (vld_q[s][0] & vld_q[s][1]) | (vld_q[s][0] & vld_q[s][2]) |
                             (vld_q[s][1] & vld_q[s][2]);
            end
`ifdef TMR_ERR_INJECT_EN
            if (inj_i && (32'(inj_stage_i) == s) && (32'(inj_copy_i) == c))
               dat_d[s][c] = dat_d[s][c] ^ inj_mask_i;
`endif
         end
         if ((dat_q[s][0] != dat_q[s][1]) || (dat_q[s][1] != dat_q[s][2]) ||
             (vld_q[s] != 3'b000 && vld_q[s] != 3'b111))
            mis = 1'b1;
      end
      err_d = mis;
      if (clr_cnt_i)                 cnt_d = '0;
      else if (mis && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
      else                           cnt_d = cnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < DEPTH; s++) begin
            for (int c = 0; c < 3; c++) dat_q[s][c] <= RST_VAL;
            vld_q[s] <= 3'b000;
         end
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         for (int s = 0; s < DEPTH; s++) begin
            for (int c = 0; c < 3; c++) dat_q[s][c] <= dat_d[s][c];
            vld_q[s] <= vld_d[s];
         end
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout_a  = dat_q[DEPTH-1][0];
   assign dout_b  = dat_q[DEPTH-1][1];
   assign dout_c  = dat_q[DEPTH-1][2];
   assign dout_v  = maj(dat_q[DEPTH-1][0], dat_q[DEPTH-1][1], dat_q[DEPTH-1][2]);
   assign vld_o   = (vld_q[DEPTH-1][0] & vld_q[DEPTH-1][1]) | (vld_q[DEPTH-1][0] & vld_q[DEPTH-1][2]) |
                    (vld_q[DEPTH-1][1] & vld_q[DEPTH-1][2]);
   assign err_o   = err_q;
   assign err_cnt = cnt_q;

endmodule

// File: tb/tb_tmr_voted_pipeline.sv
// Scoreboard bench for tmr_voted_pipeline: the driver pushes hand-computed voted values, and a monitor pops them as valid data reaches the output.
// Injection scenarios run only when TMR_ERR_INJECT_EN is defined.
module tb_tmr_voted_pipeline;
  localparam int W = 8;
  localparam int D = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rstn;
  logic en_i, vld_i, clr_cnt_i;
  logic [W-1:0] din_a, din_b, din_c;
  logic [W-1:0] dout_a, dout_b, dout_c, dout_v;
  logic vld_o, err_o;
  logic [CW-1:0] err_cnt;
`ifdef TMR_ERR_INJECT_EN
  logic inj_i;
  logic [3:0] inj_stage_i;
  logic [1:0] inj_copy_i;
  logic [W-1:0] inj_mask_i;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic chk_err = 1'b1;

  tmr_voted_pipeline #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .RST_VAL(8'h5A)) dut (
    .clk(clk), .rstn(rstn), .en_i(en_i), .vld_i(vld_i),
    .din_a(din_a), .din_b(din_b), .din_c(din_c),
    .dout_a(dout_a), .dout_b(dout_b), .dout_c(dout_c), .dout_v(dout_v),
    .vld_o(vld_o), .err_o(err_o), .err_cnt(err_cnt),
`ifdef TMR_ERR_INJECT_EN
    .inj_i(inj_i), .inj_stage_i(inj_stage_i), .inj_copy_i(inj_copy_i), .inj_mask_i(inj_mask_i),
`endif
    .clr_cnt_i(clr_cnt_i)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // one driven cycle: inputs set after a falling edge, expected voted value queued if valid
  task automatic cyc(input logic en, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] c, input logic [W-1:0] exp);
    en_i = en; vld_i = v; din_a = a; din_b = b; din_c = c;
    if (en && v) exp_q.push_back(exp);
    @(negedge clk);
  endtask

  // monitor
  initial begin
    logic en_s, rst_s, have_prev, prev_vld;
    logic [W-1:0] prev_v, exp;
    have_prev = 1'b0; prev_vld = 1'b0; prev_v = '0;
    forever begin
      @(posedge clk);
      en_s = en_i; rst_s = rstn;
      #2;
      if (!rst_s || !rstn) begin
        have_prev = 1'b0;
      end else begin
        if (chk_err) begin
          chk("err_o_low", 32'(err_o), 32'd0);
          chk("copies_equal", 32'((dout_a == dout_v) && (dout_b == dout_v) && (dout_c == dout_v)), 32'd1);
        end
        if (en_s && vld_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(dout_v), 32'hFFFF_FFFF);
          end else begin
            exp = exp_q.pop_front();
            chk("dout_v", 32'(dout_v), 32'(exp));
          end
        end else if (!en_s && have_prev) begin
          chk("hold_dout_v", 32'(dout_v), 32'(prev_v));
          chk("hold_vld_o", 32'(vld_o), 32'(prev_vld));
        end
        prev_v = dout_v; prev_vld = vld_o; have_prev = 1'b1;
      end
    end
  end

  // stimulus
  initial begin
    rstn = 1'b0; en_i = 1'b0; vld_i = 1'b0; clr_cnt_i = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
`ifdef TMR_ERR_INJECT_EN
    inj_i = 1'b0; inj_stage_i = '0; inj_copy_i = 2'd3; inj_mask_i = '0;
`endif
    @(negedge clk); @(negedge clk);
    chk("rst_dout_a", 32'(dout_a), 32'h5A);
    chk("rst_dout_b", 32'(dout_b), 32'h5A);
    chk("rst_dout_c", 32'(dout_c), 32'h5A);
    chk("rst_dout_v", 32'(dout_v), 32'h5A);
    chk("rst_vld_o", 32'(vld_o), 32'd0);
    chk("rst_err_o", 32'(err_o), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rstn = 1'b1;

    // fill, then stall for five edges
    cyc(1'b1, 1'b1, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    cyc(1'b1, 1'b1, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("stall_dout_v", 32'(dout_v), 32'h3C);
    chk("stall_vld_o", 32'(vld_o), 32'd1);

    // mismatched input copies are voted silently
    cyc(1'b1, 1'b1, 8'hFF, 8'h0F, 8'hF0, 8'hFF);
    cyc(1'b1, 1'b1, 8'hAA, 8'hAA, 8'h55, 8'hAA);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 8'h81, 8'h18, 8'h42, 8'h00);
    cyc(1'b1, 1'b0, 8'h11, 8'h22, 8'h44, 8'h00);
    cyc(1'b1, 1'b1, 8'h0F, 8'h33, 8'h55, 8'h17);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("flush_vld_o", 32'(vld_o), 32'd0);
    chk("clean_err_cnt", 32'(err_cnt), 32'd0);

`ifdef TMR_ERR_INJECT_EN
    // single upset in copy B of the last stage while stalled; pipeline holds 8'h00
    chk_err = 1'b0;
    en_i = 1'b0; inj_i = 1'b1; inj_stage_i = 4'd1; inj_copy_i = 2'd1; inj_mask_i = 8'h01;
    @(negedge clk);
    inj_i = 1'b0;
    chk("inj_dout_b", 32'(dout_b), 32'h01);
    chk("inj_dout_v", 32'(dout_v), 32'h00);
    chk("inj_err_pre", 32'(err_o), 32'd0);
    @(negedge clk);
    chk("inj_dout_b_fixed", 32'(dout_b), 32'h00);
    chk("inj_err_o", 32'(err_o), 32'd1);
    chk("inj_err_cnt", 32'(err_cnt), 32'd1);
    @(negedge clk);
    chk("inj_err_clear", 32'(err_o), 32'd0);
    // five consecutive upsets saturate the two-bit counter
    inj_i = 1'b1; inj_stage_i = 4'd0; inj_copy_i = 2'd2;
    for (int i = 0; i < 5; i++) @(negedge clk);
    inj_i = 1'b0;
    @(negedge clk);
    chk("sat_err_cnt", 32'(err_cnt), 32'd3);
    inj_i = 1'b1; clr_cnt_i = 1'b1;
    @(negedge clk);
    inj_i = 1'b0; clr_cnt_i = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    // out-of-range stage is ignored
    inj_i = 1'b1; inj_stage_i = 4'd9; inj_copy_i = 2'd0;
    @(negedge clk);
    inj_i = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("oor_err_o", 32'(err_o), 32'd0);
    chk("oor_dout_a", 32'(dout_a), 32'h00);
    chk_err = 1'b1;
`endif

    // reset mid-stream with data in flight
    cyc(1'b1, 1'b1, 8'h66, 8'h66, 8'h66, 8'h66);
    cyc(1'b1, 1'b1, 8'h77, 8'h77, 8'h77, 8'h77);
    en_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_dout_a", 32'(dout_a), 32'h5A);
    chk("async_rst_dout_v", 32'(dout_v), 32'h5A);
    chk("async_rst_vld_o", 32'(vld_o), 32'd0);
    chk("async_rst_err_o", 32'(err_o), 32'd0);
    chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b1, 1'b1, 8'hC3, 8'h3C, 8'hC3, 8'hC3);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
